// File: rtl/parity_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_serializer_pkg
// Purpose  : Shared state encodings and parity-mode constants for the
//            parity frame serializer and its downstream serial checker.
// Revision : 1.0 - initial release
// ============================================================================
package parity_frame_serializer_pkg;

  // Serializer FSM encoding; 2'b11 is unreachable and recovers to idle.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SHIFT  = 2'b01,
    S_PARITY = 2'b10
  } state_t;

  // Parity modes: even means the whole frame (data + parity) has an even
  // number of ones, odd means it has an odd number of ones.
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage : parity_frame_serializer_pkg
`default_nettype wire

// File: rtl/parity_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_serializer
// Purpose  : Accepts a WIDTH-bit word on a load/ready handshake, shifts it out
//            LSB-first one bit per clock and appends a parity bit, forming a
//            WIDTH+1 bit serial frame for the downstream parity checker.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_serializer
  import parity_frame_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ODD   = PAR_EVEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_end
);

  // Counter is wide enough to hold WIDTH itself, so it never wraps in a frame.
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          ODD_BIT  = (ODD != 0);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("parity_frame_serializer: WIDTH must be within 2..32");
  end

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             par;

  // Ready is purely a decode of the idle state so it is high during reset.
  assign ready = (state == S_IDLE);

  // Frame FSM: shift register, bit counter, parity accumulator and the
  // registered serial outputs all advance together in this one block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            // Bit 0 goes straight to the output; the rest waits in sreg.
            sout       <= data_in[0];
            sout_valid <= 1'b1;
            frame_end  <= 1'b0;
            sreg       <= data_in >> 1;
            par        <= ODD_BIT ^ data_in[0];
            cnt        <= CNT_ONE;
            state      <= S_SHIFT;
          end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_end  <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (cnt != CNT_LAST) begin
            sout <= sreg[0];
            sreg <= sreg >> 1;
            par  <= par ^ sreg[0];
            cnt  <= cnt + CNT_ONE;
          end else begin
            // All data bits are out; par already folds in the mode bit.
            sout      <= par;
            frame_end <= 1'b1;
            state     <= S_PARITY;
          end
        end

        S_PARITY: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_end  <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_end  <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule : parity_frame_serializer
`default_nettype wire

// File: tb/tb_parity_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_serializer
// Purpose  : Self-checking bench for parity_frame_serializer. Two instances
//            (even and odd parity) share one stimulus stream and are compared
//            every cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready0, sout0, sv0, fe0;
  logic             ready1, sout1, sv1, fe1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame still to be shown, as a queue of bits built
  // from the word and an even-parity bit; the odd instance inverts that bit.
  bit m_valid = 1'b0;
  bit m_bit   = 1'b0;
  bit m_end   = 1'b0;
  bit m_q[$];

  // Running XOR of observed frame bits, as a downstream checker would keep.
  bit run0 = 1'b0;
  bit run1 = 1'b0;

  always #5 clk = ~clk;

  parity_frame_serializer #(.WIDTH(WIDTH), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready0), .sout(sout0), .sout_valid(sv0), .frame_end(fe0)
  );

  parity_frame_serializer #(.WIDTH(WIDTH), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready1), .sout(sout1), .sout_valid(sv1), .frame_end(fe1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_bit   = 1'b0;
    m_end   = 1'b0;
    run0    = 1'b0;
    run1    = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs present at it.
  task automatic model_edge(input bit ld, input logic [WIDTH-1:0] d);
    if (!m_valid) begin
      if (ld) begin
        for (int i = 0; i < WIDTH; i++) m_q.push_back(d[i]);
        m_q.push_back(bit'($countones(d) % 2));
        m_bit   = m_q.pop_front();
        m_valid = 1'b1;
        m_end   = 1'b0;
      end
    end else if (m_q.size() > 0) begin
      m_bit = m_q.pop_front();
      m_end = (m_q.size() == 0);
    end else begin
      m_valid = 1'b0;
      m_bit   = 1'b0;
      m_end   = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("even_sout",  sout0,  m_bit);
    chk("even_valid", sv0,    m_valid);
    chk("even_end",   fe0,    m_end);
    chk("even_ready", ready0, !m_valid);
    chk("odd_sout",   sout1,  m_bit ^ m_end);
    chk("odd_valid",  sv1,    m_valid);
    chk("odd_end",    fe1,    m_end);
    chk("odd_ready",  ready1, !m_valid);
    if (sv0) run0 = run0 ^ sout0;
    if (sv1) run1 = run1 ^ sout1;
    if (m_end) begin
      chk("even_frame_parity", run0, 0);
      chk("odd_frame_parity",  run1, 1);
      run0 = 1'b0;
      run1 = 1'b0;
    end
  endtask

  // One clock: inputs change away from the edge, outputs checked at negedge.
  task automatic step(input bit ld, input logic [WIDTH-1:0] d);
    load    = ld;
    data_in = d;
    @(posedge clk);
    model_edge(ld, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] d);
    step(1'b1, d);
    for (int i = 0; i < WIDTH + 2; i++) step(1'b0, WIDTH'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Directed frames: mixed patterns and both parity outcomes.
    run_frame(8'hA5);
    run_frame(8'h07);
    run_frame(8'h00);
    run_frame(8'hFF);

    // Loads during a frame must be ignored, including at the parity exit.
    step(1'b1, 8'h3C);
    for (int i = 1; i <= WIDTH + 3; i++)
      step((i == 3) || (i == 9), (i == 3 || i == 9) ? 8'hFF : 8'h00);

    // Back-to-back frames with load held high.
    step(1'b1, 8'h01);
    for (int i = 0; i < 2 * (WIDTH + 2) - 1; i++) step(1'b1, 8'h80);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    // Asynchronous reset in the middle of a frame, away from any edge.
    step(1'b1, 8'h5A);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    #3 rst = 1'b0;
    run_frame(8'hA5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, WIDTH'($urandom));
    for (int i = 0; i < WIDTH + 2; i++) step(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_parity_frame_serializer
`default_nettype wire
